// File: rtl/axi4_ram_writer.sv
// AXI4 burst write master: fills a RAM window with zeros or a word-index pattern, one burst at a time.
// Optional ABORT_ON_ERR_EN: a non-OKAY BRESP ends the operation after the current burst.
module axi4_ram_writer #(
    parameter int              AW          = 32,
    parameter logic [AW-1:0]   BASE_ADDR   = '0,
    parameter int              RAM_BYTES   = 65536,
    parameter int              BURST_BEATS = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start_write,
    input  logic          clear,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] M_AXI_AWADDR,
    output logic [7:0]    M_AXI_AWLEN,
    output logic [2:0]    M_AXI_AWSIZE,
    output logic [1:0]    M_AXI_AWBURST,
    output logic          M_AXI_AWVALID,
    input  logic          M_AXI_AWREADY,
    output logic [31:0]   M_AXI_WDATA,
    output logic [3:0]    M_AXI_WSTRB,
    output logic          M_AXI_WLAST,
    output logic          M_AXI_WVALID,
    input  logic          M_AXI_WREADY,
    input  logic [1:0]    M_AXI_BRESP,
    input  logic          M_AXI_BVALID,
    output logic          M_AXI_BREADY
);
    localparam int            BURST_BYTES = BURST_BEATS * 4;
    localparam logic [AW-1:0] LAST_ADDR   = BASE_ADDR + AW'(RAM_BYTES - BURST_BYTES);
    localparam logic [8:0]    LAST_BEAT   = 9'(BURST_BEATS - 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DONE} state_t;

    state_t      state;
    logic        clear_q;
    logic [31:0] word_ctr;
    logic [8:0]  beat_ctr;
    logic        stop_op;

    assign M_AXI_AWLEN   = 8'(BURST_BEATS - 1);
    assign M_AXI_AWSIZE  = 3'b010;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WSTRB   = 4'hF;

    // The final burst is recognised by its address, so no separate burst counter is kept.
`ifdef ABORT_ON_ERR_EN
    assign stop_op = (M_AXI_AWADDR == LAST_ADDR) || (M_AXI_BRESP != 2'b00);
`else
    assign stop_op = (M_AXI_AWADDR == LAST_ADDR);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            clear_q       <= 1'b0;
            word_ctr      <= '0;
            beat_ctr      <= '0;
            M_AXI_AWADDR  <= BASE_ADDR;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WLAST   <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_write) begin
                        clear_q      <= clear;
                        error        <= 1'b0;
                        word_ctr     <= '0;
                        beat_ctr     <= '0;
                        M_AXI_AWADDR <= BASE_ADDR;
                        busy         <= 1'b1;
                        state        <= ADDR;
                    end
                end
                ADDR: begin
                    if (!M_AXI_AWVALID) begin
                        M_AXI_AWVALID <= 1'b1;
                    end else if (M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                        beat_ctr      <= '0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    // First cycle presents beat 0; afterwards each accepted beat preloads the next.
                    if (!M_AXI_WVALID) begin
                        M_AXI_WVALID <= 1'b1;
                        M_AXI_WDATA  <= clear_q ? 32'd0 : word_ctr;
                        M_AXI_WLAST  <= (beat_ctr == LAST_BEAT);
                    end else if (M_AXI_WREADY) begin
                        word_ctr <= word_ctr + 32'd1;
                        beat_ctr <= beat_ctr + 9'd1;
                        if (M_AXI_WLAST) begin
                            M_AXI_WVALID <= 1'b0;
                            M_AXI_WLAST  <= 1'b0;
                            state        <= RESP;
                        end else begin
                            M_AXI_WDATA <= clear_q ? 32'd0 : word_ctr + 32'd1;
                            M_AXI_WLAST <= ((beat_ctr + 9'd1) == LAST_BEAT);
                        end
                    end
                end
                RESP: begin
                    if (!M_AXI_BREADY) begin
                        M_AXI_BREADY <= 1'b1;
                    end else if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        if (M_AXI_BRESP != 2'b00)
                            error <= 1'b1;
                        if (stop_op) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            M_AXI_AWADDR <= M_AXI_AWADDR + AW'(BURST_BYTES);
                            state        <= ADDR;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
